// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, opcode constants and IF/ID control encoding
package fetch_stage_pkg;
    localparam int ISIZE_DEF = 16;
    localparam int DSIZE_DEF = 32;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;
    typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD, IFID_BUBBLE} ifid_ctl_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: pipeline register with hold, bubble (NOP, invalid) and load controls
module if_id_reg #(
    parameter int ISIZE = 16,
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic             load,
    input  logic [DSIZE-1:0] next_instr,
    input  logic [ISIZE-1:0] next_pc,
    output logic [DSIZE-1:0] instr,
    output logic [ISIZE-1:0] pc,
    output logic             valid
);
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= next_instr;
            pc    <= next_pc;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the registered-address imem and fills IF/ID
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ISIZE = ISIZE_DEF,
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [DSIZE-1:0] imem_data,
    output logic [ISIZE-1:0] pc,
    output logic [DSIZE-1:0] if_id_instr,
    output logic [ISIZE-1:0] if_id_pc,
    output logic             if_id_valid,
    output logic             halted,
    output logic [31:0]      fetch_count
);
    logic [ISIZE-1:0] pc_next;
    logic             is_halt;
    ifid_ctl_e        ctl;

    assign is_halt = imem_data[DSIZE-1 -: OP_W] == OP_HALT;

    // imem_data -> is_halt -> pc_next -> imem_addr is a real combinational path; constrain it
    always_comb begin
        pc_next = rst ? '0 :
                  redirect ? redirect_pc :
                  (halted || stall || is_halt) ? pc : pc + ISIZE'(1);
        ctl = redirect ? IFID_BUBBLE :
              halted ? (stall ? IFID_HOLD : IFID_BUBBLE) :
              stall ? IFID_HOLD : IFID_LOAD;
    end

    assign imem_addr = pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc <= pc_next;
            if (redirect) begin
                halted <= 1'b0;
            end else if (ctl == IFID_LOAD) begin
                halted      <= is_halt;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(.ISIZE(ISIZE), .DSIZE(DSIZE)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .bubble     (ctl == IFID_BUBBLE),
        .load       (ctl == IFID_LOAD),
        .next_instr (imem_data),
        .next_pc    (pc),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .valid      (if_id_valid)
    );
endmodule
